// File: rtl/boss_attack_sched.sv
// Boss attack scheduler: sequences normal/big bullet launches by fight phase, with intro delay and post-hit stun.
// Latency: all outputs registered; a launch decision made on an edge appears on o_fire right after that edge.
// Backpressure: busy slots are masked out; a due volley/big shot with nothing free holds its counter at 0 and retries.
module boss_attack_sched #(
    parameter int         INTRO_TICKS = 16,
    parameter int         FAN_PERIOD  = 12,
    parameter int         BIG_PERIOD  = 24,
    parameter int         STUN_TICKS  = 32,
    parameter logic [7:0] HP_P2       = 8'd128,
    parameter logic [7:0] HP_P3       = 8'd64
) (
    input  logic       i_clk22,
    input  logic       i_rst,
    input  logic       i_boss,
    input  logic [7:0] i_boss_hp,
    input  logic [5:0] i_slot_busy,
    input  logic       i_shot,
    output logic [5:0] o_fire,
    output logic [1:0] o_phase,
    output logic       o_stun,
    output logic [7:0] o_volley_cnt
);

    // Reload values; parameters are limited to 1..256 so PARAM-1 always fits in 8 bits.
    localparam logic [7:0] L_INTRO_M1 = 8'(INTRO_TICKS - 1);
    localparam logic [7:0] L_FAN_M1   = 8'(FAN_PERIOD - 1);
    localparam logic [7:0] L_BIG_M1   = 8'(BIG_PERIOD - 1);
    localparam logic [7:0] L_STUN_M1  = 8'(STUN_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INTRO,
        S_ATTACK,
        S_STUN,
        S_DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_intro_cnt, w_intro_nxt;
    logic [7:0] r_fan_cnt, w_fan_nxt;
    logic [7:0] r_big_cnt, w_big_nxt;
    logic [7:0] r_stun_cnt, w_stun_cnt_nxt;
    logic       r_alt, w_alt_nxt;
    logic [5:0] r_fire, w_fire_nxt;
    logic [1:0] r_phase, w_phase_nxt;
    logic       r_stun, w_stun_nxt;
    logic [7:0] r_volley_cnt, w_volley_nxt;

    logic [1:0] w_hp_phase;
    logic [1:0] w_phase_max;
    logic [4:0] w_mask;
    logic [4:0] w_launch;

    // Phase implied by the current hit points; the fight only ever moves forward through phases.
    assign w_hp_phase  = (i_boss_hp >= HP_P2) ? 2'd1 :
                         (i_boss_hp >= HP_P3) ? 2'd2 : 2'd3;
    assign w_phase_max = (w_hp_phase > r_phase) ? w_hp_phase : r_phase;

    // Normal-volley pattern for the current phase; phase 3 alternates between two interleaved fans.
    always_comb begin
        w_mask = 5'b00000;
        case (r_phase)
            2'd1:    w_mask = 5'b01110;
            2'd2:    w_mask = 5'b11111;
            2'd3:    w_mask = r_alt ? 5'b01010 : 5'b10101;
            default: w_mask = 5'b00000;
        endcase
    end

    assign w_launch = w_mask & ~i_slot_busy[4:0];

    // Next-state and next-output logic; fire defaults to 0 so each launch is a single-cycle pulse.
    always_comb begin
        w_state_nxt    = r_state;
        w_intro_nxt    = r_intro_cnt;
        w_fan_nxt      = r_fan_cnt;
        w_big_nxt      = r_big_cnt;
        w_stun_cnt_nxt = r_stun_cnt;
        w_alt_nxt      = r_alt;
        w_fire_nxt     = 6'b000000;
        w_phase_nxt    = r_phase;
        w_stun_nxt     = r_stun;
        case (r_state)
            S_IDLE: begin
                // boss is known high here: boss=0 is handled as a clear in the register process
                w_state_nxt = S_INTRO;
                w_intro_nxt = L_INTRO_M1;
            end
            S_INTRO: begin
                if (r_intro_cnt != 8'd0) begin
                    w_intro_nxt = r_intro_cnt - 8'd1;
                end else begin
                    w_state_nxt = S_ATTACK;
                    w_fan_nxt   = 8'd0;
                    w_big_nxt   = L_BIG_M1;
                    w_phase_nxt = w_hp_phase;
                end
            end
            S_ATTACK: begin
                w_phase_nxt = w_phase_max;
                if (i_boss_hp == 8'd0) begin
                    w_state_nxt = S_DONE;
                end else if (i_shot) begin
                    // a hit suppresses anything due this edge; big_cnt stays frozen through the stun
                    w_state_nxt    = S_STUN;
                    w_stun_nxt     = 1'b1;
                    w_stun_cnt_nxt = L_STUN_M1;
                end else begin
                    if (r_fan_cnt == 8'd0) begin
                        if (w_launch != 5'b00000) begin
                            w_fire_nxt[4:0] = w_launch;
                            w_fan_nxt       = L_FAN_M1;
                            w_alt_nxt       = ~r_alt;
                        end
                    end else begin
                        w_fan_nxt = r_fan_cnt - 8'd1;
                    end
                    if (r_big_cnt == 8'd0) begin
                        if ((r_phase >= 2'd2) && !i_slot_busy[5]) begin
                            w_fire_nxt[5] = 1'b1;
                            w_big_nxt     = L_BIG_M1;
                        end
                    end else begin
                        w_big_nxt = r_big_cnt - 8'd1;
                    end
                end
            end
            S_STUN: begin
                if (i_boss_hp == 8'd0) begin
                    w_state_nxt = S_DONE;
                    w_stun_nxt  = 1'b0;
                end else if (r_stun_cnt != 8'd0) begin
                    w_stun_cnt_nxt = r_stun_cnt - 8'd1;
                end else begin
                    w_state_nxt = S_ATTACK;
                    w_stun_nxt  = 1'b0;
                    w_fan_nxt   = L_FAN_M1;
                end
            end
            S_DONE: begin
                w_stun_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_volley_nxt = r_volley_cnt + {7'd0, (w_fire_nxt != 6'b000000)};
    end

    // State and output registers; reset or boss dropping clears the whole fight on the same edge.
    always_ff @(posedge i_clk22) begin
        if (i_rst || !i_boss) begin
            r_state      <= S_IDLE;
            r_intro_cnt  <= 8'd0;
            r_fan_cnt    <= 8'd0;
            r_big_cnt    <= 8'd0;
            r_stun_cnt   <= 8'd0;
            r_alt        <= 1'b0;
            r_fire       <= 6'b000000;
            r_phase      <= 2'd0;
            r_stun       <= 1'b0;
            r_volley_cnt <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_intro_cnt  <= w_intro_nxt;
            r_fan_cnt    <= w_fan_nxt;
            r_big_cnt    <= w_big_nxt;
            r_stun_cnt   <= w_stun_cnt_nxt;
            r_alt        <= w_alt_nxt;
            r_fire       <= w_fire_nxt;
            r_phase      <= w_phase_nxt;
            r_stun       <= w_stun_nxt;
            r_volley_cnt <= w_volley_nxt;
        end
    end

    assign o_fire       = r_fire;
    assign o_phase      = r_phase;
    assign o_stun       = r_stun;
    assign o_volley_cnt = r_volley_cnt;

endmodule

// File: tb/tb_boss_attack_sched.sv
// Bench for boss_attack_sched: directed fight scenarios followed by randomized traffic.
// Expected outputs come from a deadline-based reference model (edge numbers, not counters).
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
module tb_boss_attack_sched;

    localparam int INTRO = 16;
    localparam int FAN   = 12;
    localparam int BIG   = 24;
    localparam int STUNT = 32;

    logic       clk22 = 1'b0;
    logic       rst   = 1'b1;
    logic       boss  = 1'b0;
    logic [7:0] hp    = 8'd200;
    logic [5:0] busy  = 6'b000000;
    logic       shot  = 1'b0;
    logic [5:0] fire;
    logic [1:0] phase;
    logic       stun;
    logic [7:0] volley;

    int n_cmp  = 0;
    int n_fail = 0;

    boss_attack_sched dut (
        .i_clk22     (clk22),
        .i_rst       (rst),
        .i_boss      (boss),
        .i_boss_hp   (hp),
        .i_slot_busy (busy),
        .i_shot      (shot),
        .o_fire      (fire),
        .o_phase     (phase),
        .o_stun      (stun),
        .o_volley_cnt(volley)
    );

    always #5 clk22 = ~clk22;

    // ---------------- reference model ----------------
    // modes: 0 idle, 1 intro, 2 attack, 3 stunned, 4 done
    int         m_mode = 0;
    int         m_e = 0;          // absolute rising-edge index
    int         m_attack_at = 0;  // edge on which intro hands over to attack
    int         m_fan_due = 0;    // earliest edge a normal volley may launch
    int         m_big_due = 0;    // earliest edge a big bullet may launch
    int         m_big_rem = 0;    // big-bullet wait remaining when a stun began
    int         m_stun_end = 0;   // edge on which the stun ends
    bit         m_alt = 0;
    logic [5:0] x_fire = '0;
    logic [1:0] x_phase = '0;
    logic       x_stun = 1'b0;
    logic [7:0] x_volley = '0;

    function automatic logic [1:0] hp_phase(input logic [7:0] h);
        if (h >= 8'd128) return 2'd1;
        if (h >= 8'd64)  return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [4:0] pattern(input logic [1:0] ph, input bit alt);
        if (ph == 2'd1) return 5'b01110;
        if (ph == 2'd2) return 5'b11111;
        if (ph == 2'd3) return alt ? 5'b01010 : 5'b10101;
        return 5'b00000;
    endfunction

    task automatic model_step();
        logic [5:0] f;
        logic [1:0] np;
        logic [4:0] l;
        f = '0;
        m_e++;
        if (rst || !boss) begin
            m_mode = 0; x_phase = 0; x_stun = 0; x_volley = 0; m_alt = 0; x_fire = 0;
            return;
        end
        case (m_mode)
            0: begin
                m_mode = 1;
                m_attack_at = m_e + INTRO;
            end
            1: if (m_e == m_attack_at) begin
                m_mode = 2;
                m_fan_due = m_e + 1;
                m_big_due = m_e + BIG;
                x_phase = hp_phase(hp);
            end
            2: begin
                np = (hp_phase(hp) > x_phase) ? hp_phase(hp) : x_phase;
                if (hp == 0) begin
                    m_mode = 4;
                end else if (shot) begin
                    m_mode = 3;
                    x_stun = 1;
                    m_stun_end = m_e + STUNT;
                    m_big_rem = m_big_due - m_e;
                end else begin
                    if (m_e >= m_fan_due) begin
                        l = pattern(x_phase, m_alt) & ~busy[4:0];
                        if (l != 0) begin
                            f[4:0] = l;
                            m_fan_due = m_e + FAN;
                            m_alt = !m_alt;
                        end
                    end
                    if (x_phase >= 2 && m_e >= m_big_due && !busy[5]) begin
                        f[5] = 1'b1;
                        m_big_due = m_e + BIG;
                    end
                end
                x_phase = np;
            end
            3: begin
                if (hp == 0) begin
                    m_mode = 4;
                    x_stun = 0;
                end else if (m_e == m_stun_end) begin
                    m_mode = 2;
                    x_stun = 0;
                    m_fan_due = m_e + FAN;
                    m_big_due = m_e + 1 + ((m_big_rem > 0) ? m_big_rem : 0);
                end
            end
            default: x_stun = 0;
        endcase
        x_fire = f;
        if (f != 0) x_volley = x_volley + 8'd1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_e);
        end
    endtask

    // One rising edge, model update, then compare every output on the falling edge.
    task automatic cyc();
        @(posedge clk22);
        model_step();
        @(negedge clk22);
        check("fire",   {2'b00, fire},  {2'b00, x_fire});
        check("phase",  {6'd0, phase},  {6'd0, x_phase});
        check("stun",   {7'd0, stun},   {7'd0, x_stun});
        check("volley", volley,         x_volley);
    endtask

    logic [7:0] saved_volley;
    int         n;

    initial begin
        // reset
        repeat (3) cyc();
        check("rst_fire", {2'b00, fire}, 8'h00);
        check("rst_volley", volley, 8'h00);

        // phase 1 intro timing: E0 is the first edge with boss high
        rst = 1'b0; boss = 1'b1; hp = 8'd200; busy = '0;
        repeat (18) cyc();
        check("first_volley_E17", {2'b00, fire}, 8'h0E);
        check("phase1", {6'd0, phase}, 8'd1);
        repeat (12) cyc();
        check("second_volley_E29", {2'b00, fire}, 8'h0E);

        // busy masking and retry
        busy = 6'b000100;
        repeat (12) cyc();
        check("masked_E41", {2'b00, fire}, 8'h0A);
        busy = 6'b001110;
        repeat (12) cyc();
        check("all_busy_E53", {2'b00, fire}, 8'h00);
        repeat (3) cyc();
        busy = '0;
        cyc();
        check("retry_E57", {2'b00, fire}, 8'h0E);

        // phase 3 alternation and phase monotonicity
        hp = 8'd50;
        repeat (12) cyc();
        check("p3_a_E69", {3'b000, fire[4:0]}, 8'h15);
        repeat (12) cyc();
        check("p3_b_E81", {3'b000, fire[4:0]}, 8'h0A);
        hp = 8'd150;
        repeat (5) cyc();
        check("phase_no_drop", {6'd0, phase}, 8'd3);

        // stun on a due edge
        n = 0;
        while (m_fan_due != m_e + 1 && n < 100) begin cyc(); n++; end
        check("reach_due_edge", 8'(m_fan_due - m_e), 8'd1);
        saved_volley = volley;
        shot = 1'b1;
        cyc();
        shot = 1'b0;
        check("shot_no_fire", {3'b000, fire[4:0]}, 8'h00);
        check("shot_stun", {7'd0, stun}, 8'd1);
        n = 1;
        while (stun && n < 100) begin
            if (n == 10) shot = 1'b1;
            cyc();
            shot = 1'b0;
            if (stun) n++;
        end
        check("stun_len", 8'(n), 8'd32);
        check("volley_suppressed", volley, saved_volley);
        repeat (11) cyc();
        check("pre_resume", {3'b000, fire[4:0]}, 8'h00);
        cyc();
        check("resume_volley", {3'b000, fire[4:0]}, 8'h15);

        // abort mid-stun
        shot = 1'b1;
        cyc();
        shot = 1'b0;
        repeat (5) cyc();
        boss = 1'b0;
        cyc();
        check("abort_fire", {2'b00, fire}, 8'h00);
        check("abort_phase", {6'd0, phase}, 8'h00);
        check("abort_stun", {7'd0, stun}, 8'h00);
        check("abort_volley", volley, 8'h00);

        // phase 2 from the start: big bullet timing
        boss = 1'b1; hp = 8'd100;
        repeat (18) cyc();
        check("p2_E17", {2'b00, fire}, 8'h1F);
        repeat (23) cyc();
        check("big_E40", {2'b00, fire}, 8'h20);
        repeat (24) cyc();
        check("big_E64", {2'b00, fire}, 8'h20);

        // hp to zero: done, no more firing
        hp = 8'd0;
        repeat (30) begin
            cyc();
            check("done_fire", {2'b00, fire}, 8'h00);
        end

        // randomized traffic against the model
        hp = 8'd220;
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 499) == 0);
            boss = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 5))
                    0: hp = 8'd0;
                    1: hp = 8'd128;
                    2: hp = 8'd127;
                    3: hp = 8'd64;
                    4: hp = 8'd63;
                    default: hp = 8'($urandom_range(1, 255));
                endcase
            end
            busy = 6'($urandom & $urandom);
            shot = ($urandom_range(0, 49) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
